// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, widths and derived-constant helpers.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned RGB_W   = 8;

  // 640x480@60 with a 100 MHz system clock
  localparam int unsigned CLK_DIV_DEF   = 4;
  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;

  localparam logic [RGB_W-1:0] COLOR_BLACK = 8'h00;

  // Total counter span of one axis
  function automatic int unsigned axis_total(input int unsigned visible, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return visible + fp + sync + bp;
  endfunction

  // First coordinate inside the sync pulse
  function automatic int unsigned sync_start(input int unsigned visible, input int unsigned fp);
    return visible + fp;
  endfunction

  // Last coordinate inside the sync pulse
  function automatic int unsigned sync_end(input int unsigned visible, input int unsigned fp,
                                           input int unsigned sync);
    return visible + fp + sync - 1;
  endfunction

  // Inclusive window test on a coordinate
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a one-clk pixel strobe every CLK_DIV clocks.
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int unsigned DIV_W = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_tick_q, pix_tick_d;

  // Mod-CLK_DIV count; strobe registered on the terminal count
  always_comb begin
    div_d      = div_q + DIV_W'(1);
    pix_tick_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d      = '0;
      pix_tick_d = 1'b1;
    end
  end

  // Divider state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pix_tick_q <= pix_tick_d;
    end
  end

  assign pix_tick = pix_tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: publishes pixel coordinate, returns blanked rgb plus syncs.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RGB_W-1:0]   rgb_in,
  output logic [COORD_W-1:0] xCoord,
  output logic [COORD_W-1:0] yCoord,
  output logic               pix_tick,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [RGB_W-1:0]   rgb_out
);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(sync_start(H_VISIBLE, H_FP));
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(sync_end(H_VISIBLE, H_FP, H_SYNC));
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(sync_start(V_VISIBLE, V_FP));
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(sync_end(V_VISIBLE, V_FP, V_SYNC));

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               frame_start_q, frame_start_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;
  logic [RGB_W-1:0]   rgb_out_q, rgb_out_d;
  logic               visible_c;
  logic               pix_tick_w;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick_w)
  );

  assign visible_c = (x_q < H_VIS) && (y_q < V_VIS);

  // Counter step and output stage, both keyed to the coordinate held before the step
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    rgb_out_d     = rgb_out_q;
    if (pix_tick_w) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + COORD_W'(1);
        end
      end else begin
        x_d = x_q + COORD_W'(1);
      end
      video_on_d = visible_c;
      hsync_d    = !in_window(x_q, HS_START, HS_END);
      vsync_d    = !in_window(y_q, VS_START, VS_END);
      rgb_out_d  = visible_c ? rgb_in : COLOR_BLACK;
    end
  end

  // Coordinate and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      rgb_out_q     <= COLOR_BLACK;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      rgb_out_q     <= rgb_out_d;
    end
  end

  assign xCoord      = x_q;
  assign yCoord      = y_q;
  assign pix_tick    = pix_tick_w;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign rgb_out     = rgb_out_q;

endmodule
